// File: rtl/rx_sample_reader.sv
// Sequences the receiver I/Q read selects on each sample strobe and stores each set atomically in a word FIFO.
// Optional RX_READER_EXT_EN adds a third word per set (packed MSB bytes, S_X state).
module rx_sample_reader #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     adc_clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     flush,
  input  logic                     rx_avail_A,
  input  logic [15:0]              rx_dout_A,
  output logic                     rd_i,
  output logic                     rd_q,
  input  logic                     pop,
  output logic [15:0]              dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         ovfl_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
`ifdef RX_READER_EXT_EN
  localparam int unsigned WPS   = 3;
`else
  localparam int unsigned WPS   = 2;
`endif

  typedef enum logic [1:0] {
    IDLE,
    S_I,
    S_Q
`ifdef RX_READER_EXT_EN
    , S_X
`endif
  } state_e;

  state_e             state_q, state_d;
  logic               rd_i_q, rd_i_d;
  logic               rd_q_q, rd_q_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [CNT_W-1:0]   ovfl_q, ovfl_d;
  logic [15:0]        mem [DEPTH];

  logic               strobe;
  logic               space_ok;
  logic               wr_en;
  logic               rd_en;
  logic               drop;

  assign strobe   = rx_avail_A && enable;
  // Free space is judged on the registered level; a same-cycle pop is not credited.
  assign space_ok = (LVL_W'(DEPTH) - level_q) >= LVL_W'(WPS);

  // Next-state, FIFO bookkeeping and drop accounting.
  always_comb begin
    state_d  = state_q;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    drop     = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovfl_d   = ovfl_q;

    case (state_q)
      IDLE: begin
        if (strobe) begin
          if (space_ok) state_d = S_I;
          else          drop    = 1'b1;
        end
      end
      S_I: begin
        wr_en   = 1'b1;
        drop    = strobe;
        state_d = S_Q;
      end
      S_Q: begin
        wr_en   = 1'b1;
        drop    = strobe;
`ifdef RX_READER_EXT_EN
        state_d = S_X;
`else
        state_d = IDLE;
`endif
      end
`ifdef RX_READER_EXT_EN
      S_X: begin
        wr_en   = 1'b1;
        drop    = strobe;
        state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase

    rd_en = pop && (level_q != '0);

    if (flush) begin
      state_d  = IDLE;
      wr_en    = 1'b0;
      rd_en    = 1'b0;
      drop     = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      level_d = level_q + LVL_W'(wr_en) - LVL_W'(rd_en);
    end

    if (drop && (ovfl_q != '1)) ovfl_d = ovfl_q + CNT_W'(1);
  end

  assign rd_i_d = (state_d == S_I);
  assign rd_q_d = (state_d == S_Q);

  always_ff @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rd_i_q   <= 1'b0;
      rd_q_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovfl_q   <= '0;
    end else begin
      state_q  <= state_d;
      rd_i_q   <= rd_i_d;
      rd_q_q   <= rd_q_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovfl_q   <= ovfl_d;
    end
  end

  // Storage is not reset; dout is forced to zero while empty so stale words never show.
  always_ff @(posedge adc_clk) begin
    if (wr_en) mem[wr_ptr_q] <= rx_dout_A;
  end

  assign rd_i     = rd_i_q;
  assign rd_q     = rd_q_q;
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign ovfl_cnt = ovfl_q;
  assign dout     = empty ? 16'h0000 : mem[rd_ptr_q];

endmodule
